fft_8_ctrl: RTL and testbench

FFT_8_CTRL -- requirements
Module: fft_8_ctrl

---
 rtl/fft_8_ctrl.sv | 177 +++++++++++++++++
 tb/tb_fft_8_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_8_ctrl.sv
// fft_8_ctrl: buffers an 8-sample frame and feeds it to an fft_8_rad2 datapath. It then drains the result bins over a valid/ready port.
// Optional FLUSH watchdog: define FFT_CTRL_TIMEOUT_EN to enable it (sticky err_timeout, frame discarded).

package fft_8_ctrl_pkg;
  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } complex_product_t;
endpackage

module fft_8_ctrl
  import fft_8_ctrl_pkg::*;
#(
  parameter int N              = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  complex_product_t         in_data,
  output logic                     fft_reset,
  output logic                     fft_enable,
  output complex_product_t         fft_data_0,
  output complex_product_t         fft_data_1,
  input  logic                     fft_out_valid,
  input  complex_product_t [N-1:0] fft_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output complex_product_t         out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     err_timeout
);

  localparam int IW   = $clog2(N);
  localparam int HALF = N / 2;
  localparam int KW   = $clog2(HALF);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    CLR,
    FEED,
    FLUSH,
    DRAIN
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic [KW-1:0]    feed_idx;
  complex_product_t sample_buf [N];
  complex_product_t res        [N];
  logic             capture;
  logic             timeout_hit;

  assign capture = (state == FLUSH) && fft_out_valid;

`ifdef FFT_CTRL_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  // A capture on the terminal cycle wins over the watchdog.
  assign timeout_hit = (state == FLUSH) && !fft_out_valid &&
                       (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state != FLUSH) tmo_cnt <= '0;
      else                tmo_cnt <= tmo_cnt + TW'(1);
      if (timeout_hit)    err_q   <= 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign err_timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  next_state = FILL;
      FILL:  if (in_valid && (wr_idx == IW'(N - 1))) next_state = CLR;
      CLR:   next_state = FEED;
      FEED:  if (feed_idx == KW'(HALF - 1)) next_state = FLUSH;
      FLUSH: begin
        if (capture)          next_state = DRAIN;
        else if (timeout_hit) next_state = FILL;
      end
      DRAIN: if (out_ready && (rd_idx == IW'(N - 1))) next_state = FILL;
      default: next_state = IDLE;
    endcase
  end

  // Indices wrap naturally at N, so they are back at zero whenever FILL or DRAIN ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      feed_idx <= '0;
    end else begin
      if (state == FILL && in_valid)   wr_idx <= wr_idx + IW'(1);
      if (state == DRAIN && out_ready) rd_idx <= rd_idx + IW'(1);
      if (state == FEED)               feed_idx <= feed_idx + KW'(1);
      else                             feed_idx <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        sample_buf[i] <= '0;
        res[i]        <= '0;
      end
    end else begin
      if (state == FILL && in_valid) sample_buf[wr_idx] <= in_data;
      if (capture) begin
        for (int i = 0; i < N; i++) res[i] <= fft_out[i];
      end
    end
  end

  // Every output is a decode of registered state; nothing passes combinationally from an input.
  always_comb begin
    in_ready   = 1'b0;
    fft_reset  = 1'b0;
    fft_enable = 1'b0;
    fft_data_0 = '0;
    fft_data_1 = '0;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: fft_reset = 1'b1;
      FILL: in_ready = 1'b1;
      CLR: begin
        fft_reset = 1'b1;
        busy      = 1'b1;
      end
      FEED: begin
        fft_enable = 1'b1;
        fft_data_0 = sample_buf[IW'(feed_idx)];
        fft_data_1 = sample_buf[IW'(feed_idx) + IW'(HALF)];
        busy       = 1'b1;
      end
      FLUSH: begin
        fft_enable = 1'b1;
        busy       = 1'b1;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = res[rd_idx];
        out_last  = (rd_idx == IW'(N - 1));
        busy      = 1'b1;
      end
      default: fft_reset = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fft_8_ctrl.sv
// tb_fft_8_ctrl: table-driven bench for fft_8_ctrl, with a stub datapath that returns bins (10*j, -j) on the 6th FLUSH cycle.
// Timeout scenarios run only when FFT_CTRL_TIMEOUT_EN is defined.

module tb_fft_8_ctrl;
  import fft_8_ctrl_pkg::*;

  localparam int N = 8;

`ifdef FFT_CTRL_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  typedef logic [102:0] obs_t;
  typedef enum int {P_IDLE, P_FILL, P_CLR, P_FEED, P_FLUSH, P_DRAIN} phase_t;

  typedef struct {
    string            name;
    phase_t           ph;
    logic             in_valid;
    complex_product_t in_data;
    logic             out_ready;
    logic             stub_on;
    logic             stub_spur;
    complex_product_t e_d0;
    complex_product_t e_d1;
    complex_product_t e_out;
    logic             e_last;
    logic             e_err;
  } vec_t;

  logic                     clk;
  logic                     reset_n;
  logic                     in_valid;
  logic                     in_ready;
  complex_product_t         in_data;
  logic                     fft_reset;
  logic                     fft_enable;
  complex_product_t         fft_data_0;
  complex_product_t         fft_data_1;
  logic                     fft_out_valid;
  complex_product_t [N-1:0] fft_out;
  logic                     out_valid;
  logic                     out_ready;
  complex_product_t         out_data;
  logic                     out_last;
  logic                     busy;
  logic                     err_timeout;

  logic stub_on;
  logic stub_spur;
  logic stub_fire;
  int   en_cnt;
  vec_t vq[$];
  int   n_vec;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fft_8_ctrl #(.N(N), .TIMEOUT_CYCLES(64)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .fft_reset    (fft_reset),
    .fft_enable   (fft_enable),
    .fft_data_0   (fft_data_0),
    .fft_data_1   (fft_data_1),
    .fft_out_valid(fft_out_valid),
    .fft_out      (fft_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  function automatic complex_product_t cp(input int re, input int im);
    complex_product_t c;
    c.re = 16'(re);
    c.im = 16'(im);
    return c;
  endfunction

  // Stub datapath: counts enabled cycles since its reset; the 10th (6th of FLUSH) carries the result.
  initial en_cnt = 0;
  always @(posedge clk) begin
    if (fft_reset)       en_cnt <= 0;
    else if (fft_enable) en_cnt <= en_cnt + 1;
  end

  assign stub_fire     = stub_on && fft_enable && (en_cnt == 9);
  assign fft_out_valid = stub_spur || stub_fire;

  always_comb begin
    for (int j = 0; j < N; j++) fft_out[j] = stub_fire ? cp(10 * j, -j) : cp(-5, 5);
  end

  function automatic vec_t mk(input string nm, input phase_t ph, input logic iv,
                              input complex_product_t id, input logic ordy,
                              input logic son, input logic spur,
                              input complex_product_t d0, input complex_product_t d1,
                              input complex_product_t od, input logic last, input logic err);
    vec_t v;
    v.name = nm;       v.ph = ph;        v.in_valid = iv;  v.in_data = id;
    v.out_ready = ordy; v.stub_on = son; v.stub_spur = spur;
    v.e_d0 = d0;       v.e_d1 = d1;      v.e_out = od;     v.e_last = last;
    v.e_err = err;
    return v;
  endfunction

  function automatic obs_t expect_bits(input vec_t v);
    logic ir, fr, en, ov, bz;
    ir = (v.ph == P_FILL);
    fr = (v.ph == P_IDLE) || (v.ph == P_CLR);
    en = (v.ph == P_FEED) || (v.ph == P_FLUSH);
    ov = (v.ph == P_DRAIN);
    bz = (v.ph == P_CLR) || (v.ph == P_FEED) || (v.ph == P_FLUSH) || (v.ph == P_DRAIN);
    return {ir, fr, en, v.e_d0, v.e_d1, ov, v.e_out, v.e_last, bz, v.e_err};
  endfunction

  // One frame of expected per-cycle behaviour; ivpat gives in_valid per FILL cycle (LSB first).
  function automatic void build_frame(input string tag, input int base, input int im_step,
                                      input bit with_idle, input logic [15:0] ivpat,
                                      input int feed_cycles, input bit timeout_run,
                                      input bit toggle_ready, input logic err, input bit spur);
    complex_product_t x [8];
    complex_product_t z;
    logic             iv;
    logic             r;
    int               got;
    int               c;
    int               j;
    z   = '0;
    got = 0;
    c   = 0;
    for (int i = 0; i < 8; i++) x[i] = cp(base + i, im_step * i);
    if (with_idle)
      vq.push_back(mk({tag, ":idle"}, P_IDLE, 1'b1, cp(-1, -1), 1'b1, 1'b1, 1'b0, z, z, z, 1'b0, err));
    while (got < 8) begin
      iv = ivpat[c % 16];
      vq.push_back(mk($sformatf("%s:fill%0d", tag, c), P_FILL, iv, iv ? x[got] : cp(999, 999),
                      1'b1, 1'b1, spur, z, z, z, 1'b0, err));
      if (iv) got++;
      c++;
    end
    vq.push_back(mk({tag, ":clr"}, P_CLR, 1'b1, cp(555, 555), 1'b1, 1'b1, spur, z, z, z, 1'b0, err));
    for (int k = 0; k < feed_cycles; k++)
      vq.push_back(mk($sformatf("%s:feed%0d", tag, k), P_FEED, 1'b1, cp(777, k), 1'b1, 1'b1, spur,
                      x[k], x[k + 4], z, 1'b0, err));
    if (feed_cycles < 4) return;
    if (timeout_run) begin
      for (int f = 0; f < 64; f++)
        vq.push_back(mk($sformatf("%s:flush%0d", tag, f), P_FLUSH, 1'b1, cp(333, f), 1'b1, 1'b0,
                        1'b0, z, z, z, 1'b0, err));
      vq.push_back(mk({tag, ":fill_after_timeout"}, P_FILL, 1'b0, cp(0, 0), 1'b1, 1'b1, 1'b0,
                      z, z, z, 1'b0, 1'b1));
      return;
    end
    for (int f = 0; f < 6; f++)
      vq.push_back(mk($sformatf("%s:flush%0d", tag, f), P_FLUSH, 1'b1, cp(333, f), 1'b1, 1'b1,
                      1'b0, z, z, z, 1'b0, err));
    j = 0;
    c = 0;
    while (j < 8) begin
      r = toggle_ready ? ((c % 4) == 0 || (c % 4) == 3) : 1'b1;
      vq.push_back(mk($sformatf("%s:drain%0d_bin%0d", tag, c, j), P_DRAIN, 1'b1, cp(444, c), r,
                      1'b1, 1'b0, z, z, cp(10 * j, -j), (j == 7), err));
      if (r) j++;
      c++;
    end
    vq.push_back(mk({tag, ":fill_next"}, P_FILL, 1'b0, cp(0, 0), 1'b1, 1'b1, 1'b0,
                    z, z, z, 1'b0, err));
  endfunction

  task automatic check_output(input string nm, input obs_t exp);
    obs_t act;
    act = {in_ready, fft_reset, fft_enable, fft_data_0, fft_data_1, out_valid, out_data,
           out_last, busy, err_timeout};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic apply_stimulus();
    foreach (vq[i]) begin
      in_valid  = vq[i].in_valid;
      in_data   = vq[i].in_data;
      out_ready = vq[i].out_ready;
      stub_on   = vq[i].stub_on;
      stub_spur = vq[i].stub_spur;
      check_output(vq[i].name, expect_bits(vq[i]));
      @(posedge clk);
      #1;
    end
    vq.delete();
  endtask

  initial begin
    complex_product_t z;
    z         = '0;
    n_vec     = 0;
    n_bad     = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    stub_on   = 1'b1;
    stub_spur = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_hold",
                 expect_bits(mk("", P_IDLE, 1'b0, z, 1'b0, 1'b1, 1'b0, z, z, z, 1'b0, 1'b0)));
    reset_n = 1'b1;

    build_frame("f1", 0, 0, 1'b1, 16'hFFFF, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    build_frame("f2", 100, -3, 1'b0, 16'hFDCD, 4, 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef FFT_CTRL_TIMEOUT_EN
    build_frame("to", 50, 1, 1'b0, 16'hFFFF, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    build_frame("good", 20, 2, 1'b0, 16'hFFFF, 4, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
    apply_stimulus();

    // Reset pulsed in the middle of FEED cycle 2.
    build_frame("rst", 0, 0, 1'b0, 16'hFFFF, 2, 1'b0, 1'b0, TO_EN, 1'b0);
    apply_stimulus();
    check_output("feed2_pre_reset",
                 expect_bits(mk("", P_FEED, 1'b0, z, 1'b0, 1'b1, 1'b0, cp(2, 0), cp(6, 0), z,
                                1'b0, TO_EN)));
    #2 reset_n = 1'b0;
    #1 check_output("reset_async",
                    expect_bits(mk("", P_IDLE, 1'b0, z, 1'b0, 1'b1, 1'b0, z, z, z, 1'b0, 1'b0)));
    @(posedge clk);
    #1;
    check_output("reset_held",
                 expect_bits(mk("", P_IDLE, 1'b0, z, 1'b0, 1'b1, 1'b0, z, z, z, 1'b0, 1'b0)));
    reset_n = 1'b1;
    build_frame("post_rst", 0, 0, 1'b1, 16'hFFFF, 4, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
